// File: rtl/network_mul_arbiter_16s_12s_if.sv
// network_mul_arbiter_16s_12s_if: requester-side operand handshake and result bus of the shared multiplier arbiter
interface network_mul_arbiter_16s_12s_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*16-1:0] req_a;
    logic [N_REQ*12-1:0] req_b;
    logic [N_REQ-1:0]    res_valid;
    logic [27:0]         res_data;
    logic [TAG_W-1:0]    res_tag;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/network_mul_arbiter_16s_12s.sv
// network_mul_arbiter_16s_12s: round-robin sharing of one pipelined 16s x 12s multiplier,
// with a tag pipeline that steers each product back to its requester.
module network_mul_arbiter_16s_12s #(
    parameter int N_REQ       = 4,
    parameter int TAG_W       = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    network_mul_arbiter_16s_12s_if.slave bus,
    output logic        mul_ce,
    output logic [15:0] mul_din0,
    output logic [11:0] mul_din1,
    input  logic [27:0] mul_dout,
    output logic        busy
);
    logic [TAG_W-1:0] ptr_q, ptr_d, win;
    logic [TAG_W:0] idx;
    logic found, accept;
    logic [15:0] a_sel, din0_q, din0_d;
    logic [11:0] b_sel, din1_q, din1_d;
    logic [MUL_LATENCY-1:0] v_q, v_d;
    logic [MUL_LATENCY-1:0][TAG_W-1:0] t_q, t_d;

    always_comb begin
        win = '0;
        found = 1'b0;
        idx = '0;
        a_sel = '0;
        b_sel = '0;
        // descending scan so the requester closest to ptr is the last to overwrite win
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (idx >= (TAG_W+1)'(N_REQ)) idx = idx - (TAG_W+1)'(N_REQ);
            if (bus.req_valid[idx[TAG_W-1:0]]) begin
                win = idx[TAG_W-1:0];
                found = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win == TAG_W'(i)) begin
                a_sel = bus.req_a[16*i +: 16];
                b_sel = bus.req_b[12*i +: 12];
            end
        end
        accept = found & ~hold;
        ptr_d = accept ? (win == TAG_W'(N_REQ - 1) ? '0 : win + TAG_W'(1)) : ptr_q;
        din0_d = accept ? a_sel : din0_q;
        din1_d = accept ? b_sel : din1_q;
        v_d = hold ? v_q : {v_q[MUL_LATENCY-2:0], accept};
        t_d = hold ? t_q : {t_q[MUL_LATENCY-2:0], accept ? win : t_q[0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            din0_q <= '0;
            din1_q <= '0;
            v_q    <= '0;
            t_q    <= '0;
        end else begin
            ptr_q  <= ptr_d;
            din0_q <= din0_d;
            din1_q <= din1_d;
            v_q    <= v_d;
            t_q    <= t_d;
        end
    end

    assign bus.req_ready = accept ? N_REQ'(1) << win : '0;
    assign bus.res_valid = (v_q[MUL_LATENCY-1] & ~hold) ? N_REQ'(1) << t_q[MUL_LATENCY-1] : '0;
    assign bus.res_data  = mul_dout;
    assign bus.res_tag   = t_q[MUL_LATENCY-1];
    assign busy          = |v_q;
    assign mul_ce        = ~hold;
    assign mul_din0      = din0_q;
    assign mul_din1      = din1_q;
endmodule

// File: tb/tb_network_mul_arbiter_16s_12s.sv
// tb_network_mul_arbiter_16s_12s: directed checks of arbitration, latency, hold and reset,
// with a two-stage clock-enabled multiplier model behind the arbiter.
module tb_network_mul_arbiter_16s_12s;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hold = 1'b0;
    always #5 clk = ~clk;

    network_mul_arbiter_16s_12s_if #(.N_REQ(4), .TAG_W(2)) bus ();

    logic        mul_ce, busy;
    logic [15:0] mul_din0;
    logic [11:0] mul_din1;
    logic [27:0] mul_dout;
    logic signed [15:0] ra [4];
    logic signed [11:0] rb [4];
    logic [3:0] rv = 4'h0;

    assign bus.req_valid = rv;
    assign bus.req_a = {ra[3], ra[2], ra[1], ra[0]};
    assign bus.req_b = {rb[3], rb[2], rb[1], rb[0]};

    network_mul_arbiter_16s_12s #(.N_REQ(4), .TAG_W(2), .MUL_LATENCY(3)) dut (
        .clk(clk),
        .reset(reset),
        .hold(hold),
        .bus(bus),
        .mul_ce(mul_ce),
        .mul_din0(mul_din0),
        .mul_din1(mul_din1),
        .mul_dout(mul_dout),
        .busy(busy)
    );

    logic signed [27:0] p1, p2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 <= '0;
            p2 <= '0;
        end else if (mul_ce) begin
            p1 <= signed'(mul_din0) * signed'(mul_din1);
            p2 <= p1;
        end
    end
    assign mul_dout = p2;

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_op(input int r, input logic signed [15:0] a, input logic signed [11:0] b, input int exp);
        ra[r] = a;
        rb[r] = b;
        rv = 4'(1 << r);
        #1;
        chk("op_ready", bus.req_ready, 1 << r);
        step();
        rv = 4'h0;
        chk("op_din0", signed'(mul_din0), a);
        chk("op_din1", signed'(mul_din1), b);
        chk("op_busy", busy, 1);
        chk("op_early0", bus.res_valid, 0);
        step();
        chk("op_early1", bus.res_valid, 0);
        step();
        chk("op_valid", bus.res_valid, 1 << r);
        chk("op_data", signed'(bus.res_data), exp);
        chk("op_tag", bus.res_tag, r);
        step();
        chk("op_after", bus.res_valid, 0);
        chk("op_idle", busy, 0);
    endtask

    logic signed [15:0] fa [8];
    logic signed [11:0] fb [8];
    int fp [8];

    initial begin
        fa = '{16'sd100, -16'sd7, 16'sd1234, -16'sd1, 16'sd256, 16'sd32767, -16'sd2, 16'sd0};
        fb = '{12'sd3, 12'sd5, -12'sd10, -12'sd1, 12'sd256, 12'sd1, 12'sd2047, -12'sd5};
        fp = '{300, -35, -12340, 1, 65536, 32767, -4094, 0};
        for (int i = 0; i < 4; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        #12;
        reset = 1'b0;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tag", bus.res_tag, 0);
        chk("rst_din0", mul_din0, 0);
        chk("rst_din1", mul_din1, 0);
        chk("rst_ce", mul_ce, 1);

        single_op(1, -16'sd300, 12'sd2047, -614100);
        single_op(3, -16'sd32768, -12'sd2048, 67108864);
        single_op(3, 16'sd32767, -12'sd2048, -67106816);

        // fairness: all four valid for eight cycles from ptr=0
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra[i] = fa[i];
            rb[i] = fb[i];
        end
        for (int t = 0; t < 12; t++) begin
            if (t >= 1 && t <= 4) begin
                ra[t-1] = fa[t+3];
                rb[t-1] = fb[t+3];
            end
            rv = t < 8 ? 4'hf : 4'h0;
            #1;
            if (t < 8) chk("fair_ready", bus.req_ready, 1 << (t % 4));
            if (t >= 3 && t < 11) begin
                chk("fair_valid", bus.res_valid, 1 << ((t - 3) % 4));
                chk("fair_data", signed'(bus.res_data), fp[t-3]);
                chk("fair_tag", bus.res_tag, (t - 3) % 4);
            end else begin
                chk("fair_idle", bus.res_valid, 0);
            end
            step();
        end

        // hold for four cycles right after an accept
        ra[2] = -16'sd1000;
        rb[2] = -12'sd3;
        rv = 4'b0100;
        #1;
        chk("hold_acc_ready", bus.req_ready, 4'b0100);
        step();
        rv = 4'h0;
        chk("hold_c0", bus.res_valid, 0);
        for (int c = 1; c <= 4; c++) begin
            step();
            hold = 1'b1;
            rv = 4'b0001;
            #1;
            chk("hold_ready", bus.req_ready, 0);
            chk("hold_ce", mul_ce, 0);
            chk("hold_res", bus.res_valid, 0);
            chk("hold_busy", busy, 1);
        end
        step();
        hold = 1'b0;
        rv = 4'h0;
        #1;
        chk("hold_c5", bus.res_valid, 0);
        chk("hold_ce_back", mul_ce, 1);
        step();
        chk("hold_c6_valid", bus.res_valid, 4'b0100);
        chk("hold_c6_data", signed'(bus.res_data), 3000);
        chk("hold_c6_tag", bus.res_tag, 2);
        step();
        chk("hold_c7", bus.res_valid, 0);
        chk("hold_c7_busy", busy, 0);

        // hold while a result sits at the last stage
        ra[1] = 16'sd123;
        rb[1] = -12'sd4;
        rv = 4'b0010;
        step();
        rv = 4'h0;
        step();
        step();
        hold = 1'b1;
        #1;
        chk("s2hold_mask", bus.res_valid, 0);
        step();
        chk("s2hold_frozen", bus.res_valid, 0);
        hold = 1'b0;
        #1;
        chk("s2hold_valid", bus.res_valid, 4'b0010);
        chk("s2hold_data", signed'(bus.res_data), -492);
        step();
        chk("s2hold_after", bus.res_valid, 0);

        // reset mid-flight: ptr is 2 here, so grant order 0 then 1
        rv = 4'b0011;
        #1;
        chk("rmf_ready0", bus.req_ready, 4'b0001);
        step();
        chk("rmf_ready1", bus.req_ready, 4'b0010);
        step();
        rv = 4'h0;
        chk("rmf_busy", busy, 1);
        reset = 1'b1;
        step();
        chk("rmf_in_reset", bus.res_valid, 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rmf_no_res", bus.res_valid, 0);
            chk("rmf_idle", busy, 0);
        end
        rv = 4'b1010;
        #1;
        chk("rmf_ptr0", bus.req_ready, 4'b0010);
        rv = 4'h0;
        step();

        // rotation skip: requesters 0 and 2 valid with ptr=1
        single_op(0, 16'sd11, 12'sd13, 143);
        ra[0] = 16'sd5;
        rb[0] = 12'sd6;
        ra[2] = -16'sd9;
        rb[2] = 12'sd7;
        rv = 4'b0101;
        #1;
        chk("rot_first", bus.req_ready, 4'b0100);
        step();
        chk("rot_second", bus.req_ready, 4'b0001);
        step();
        chk("rot_third", bus.req_ready, 4'b0100);
        step();
        rv = 4'h0;
        chk("rot_res0", bus.res_valid, 4'b0100);
        chk("rot_data0", signed'(bus.res_data), -63);
        step();
        chk("rot_res1", bus.res_valid, 4'b0001);
        chk("rot_data1", signed'(bus.res_data), 30);
        step();
        chk("rot_res2", bus.res_valid, 4'b0100);
        chk("rot_data2", signed'(bus.res_data), -63);
        step();
        chk("rot_done", bus.res_valid, 0);
        chk("rot_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/network_mul_arbiter_16s_12s.md
# network_mul_arbiter_16s_12s

Round-robin arbiter and sequencer that time-shares one pipelined signed 16x12 multiplier (28-bit product) among `N_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes, registers the granted pair into the multiplier, and carries a requester tag alongside the multiplier pipeline. When the product emerges, it is steered back to the originating requester. The block sits between the convolution lanes of the network datapath and a single shared multiplier instance, with the multiplier's `clk`/`reset`/`ce` tied through this block.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TAG_W`, default 2: tag width, equal to ceil(log2(N_REQ)).
- `MUL_LATENCY`, default 3: cycles from handshake to result, fixed by the multiplier (1 operand register here plus 2 multiplier stages).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `hold` in 1: global stall; freezes the block and the multiplier.
- `req_valid` in N_REQ: requester i has an operand pair.
- `req_ready` out N_REQ: one-hot grant, combinational from `req_valid`, pointer and `hold`.
- `req_a` in N_REQ*16: signed multiplicands, requester i at bits [16i+15:16i].
- `req_b` in N_REQ*12: signed multipliers, requester i at bits [12i+11:12i].
- `mul_ce` out 1: multiplier clock enable, equal to `~hold`.
- `mul_din0` out 16: registered multiplicand to the multiplier.
- `mul_din1` out 12: registered multiplier operand to the multiplier.
- `mul_dout` in 28: multiplier product, signed.
- `res_valid` out N_REQ: one-hot result strobe to the owning requester.
- `res_data` out 28: product, shared by all requesters and qualified by `res_valid`.
- `res_tag` out TAG_W: index of the result owner.
- `busy` out 1: any operation in flight.

## Operation
- Arbitration: round-robin, with pointer `ptr` (reset 0).
  - The winner is the first i with `req_valid[i]`, scanning ptr, ptr+1, … mod N_REQ.
  - `req_ready[winner]`=1; all other ready bits are 0.
  - No winner, or `hold`=1: `req_ready`=0.
- Handshake: `req_valid[i] & req_ready[i]` at a rising edge = accept. On accept:
  - `mul_din0`<=`req_a[i]`, `mul_din1`<=`req_b[i]`.
  - Tag stage 0 <= {valid=1, tag=i}.
  - `ptr`<=(i+1) mod N_REQ.
- No accept and `hold`=0: tag stage 0 valid <= 0; `mul_din0/1` hold their value.
- Tag pipeline: 3 stages (s0, s1, s2), each {valid, tag}. It shifts every edge with `hold`=0 and is frozen when `hold`=1, mirroring the multiplier's `ce`.
- Result: `res_valid` = onehot(s2.tag) when s2.valid and `hold`=0; otherwise 0. `res_data`=`mul_dout`, `res_tag`=s2.tag.
- No result backpressure: requesters must sink the result in the cycle it is strobed.
- `busy` = s0.valid | s1.valid | s2.valid.
- Requesters must hold `req_a`/`req_b` stable while valid and not yet accepted. The block does not check this.
- Arithmetic: full-precision signed product (16s x 12s -> 28s), performed entirely in the multiplier. No saturation or rounding.

## Timing
- Reset values:
  - `req_ready`=0 (combinational, since no valid state is sampled during reset).
  - `res_valid`=0, `busy`=0, `res_tag`=0.
  - `mul_din0`=0, `mul_din1`=0, `ptr`=0.
  - All tag valids 0; `mul_ce` follows `hold`.
- Latency: accept at edge E0 → `res_valid` high in the cycle after edge E2, i.e. 3 cycles after the handshake cycle.
- Throughput: 1 accept per cycle sustained. Back-to-back accepts from different requesters return in grant order, one per cycle.
- `hold`=1:
  - No accepts.
  - No pipeline or `ptr` movement.
  - `res_valid` forced 0.
  - A result present at s2 reappears the cycle `hold` drops, since the multiplier `p_reg` is also frozen.
- Single requester continuously valid: granted every cycle; `ptr` keeps returning to it.
- Reset mid-operation: all in-flight tags are dropped and no `res_valid` follows. The multiplier's stale contents are ignored because the tags are invalid.

## Test plan
- Single op: reset, requester 1 issues a=-300, b=2047 for one accept → exactly 3 cycles later `res_valid`=4'b0010, `res_data`=-614100, `res_tag`=1; `busy` falls the next cycle.
- Fairness: all 4 valid for 8 cycles with ptr=0 → grant order 0,1,2,3,0,1,2,3; results appear in that order on 8 consecutive cycles with correct products.
- Extremes: a=-32768, b=-2048 → `res_data`=67108864. Then a=32767, b=-2048 → -67106816.
- Hold: accept at cycle 0, `hold`=1 for cycles 1-4 → no `res_valid` and no ready during hold; result strobes once in cycle 6; `mul_ce`=0 during hold.
- Reset mid-flight: accepts on two consecutive cycles, `reset` pulsed 1 cycle later → no `res_valid` ever; `busy`=0 and `ptr`=0 after reset.
- Rotation skip: only requesters 0 and 2 valid, ptr=1 → requester 2 granted first, then 0, then 2.
